// File: rtl/pipe_gap_if.sv
// pipe_gap_if: spawn handshake carrying the next pipe gap Y to the renderer.
interface pipe_gap_if #(parameter int Y_W = 10);
   logic           spawn_valid;
   logic           spawn_ready;
   logic [Y_W-1:0] gap_y;
   modport master (output spawn_valid, gap_y, input spawn_ready);
   modport slave  (input spawn_valid, gap_y, output spawn_ready);
endinterface

// File: rtl/pipe_gap_scheduler.sv
// pipe_gap_scheduler: times pipe spawns, draws a gap index from the LFSR,
// rejects/clamps it against the previous gap and offers gap Y to the renderer.
module pipe_gap_scheduler #(
   parameter int SPAWN_FRAMES = 90,
   parameter int IDX_MAX      = 23,
   parameter int MAX_STEP     = 6,
   parameter int MAX_RETRY    = 3,
   parameter int GAP_BASE     = 80,
   parameter int GAP_STEP     = 12,
   parameter int Y_W          = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       game_run_i,
   input  logic       frame_tick_i,
   input  logic [4:0] lfsr_data_i,
   output logic       lfsr_en_o,
   pipe_gap_if.master spawn_if,
   output logic [7:0] spawn_count_o,
   output logic       busy_o
);
   localparam int CW = $clog2(SPAWN_FRAMES + 1);
   localparam int RW = $clog2(MAX_RETRY + 1);
   localparam logic [CW-1:0] LAST = CW'(SPAWN_FRAMES - 1);
   localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
   localparam logic [4:0]    IMAX = 5'(IDX_MAX);
   localparam logic [4:0]    STEP = 5'(MAX_STEP);
   localparam logic [4:0]    MID  = 5'(IDX_MAX / 2);

   typedef enum logic [2:0] {IDLE, WAIT, DRAW, CHECK, OFFER} state_e;

   state_e         state_q;
   logic [CW-1:0]  cnt_q;
   logic [RW-1:0]  retry_q;
   logic [4:0]     prev_q;
   logic           lfsr_en_q;
   logic           valid_q;
   logic           busy_q;
   logic [Y_W-1:0] gap_q;
   logic [7:0]     count_q;

   logic            accept_d;
   logic [4:0]      cand_d;
   logic [4:0]      idx_d;
   logic signed [5:0] diff_d;
   logic [Y_W-1:0]  gap_d;

   // A candidate is always within 0..IDX_MAX, so clamping toward it can never leave that range.
   always_comb begin
      accept_d = lfsr_data_i <= IMAX;
      cand_d   = accept_d ? lfsr_data_i : prev_q;
      diff_d   = $signed({1'b0, cand_d}) - $signed({1'b0, prev_q});
      idx_d    = diff_d > $signed({1'b0, STEP})  ? prev_q + STEP
               : diff_d < -$signed({1'b0, STEP}) ? prev_q - STEP : cand_d;
      gap_d    = Y_W'(GAP_BASE) + Y_W'(idx_d) * Y_W'(GAP_STEP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         retry_q   <= '0;
         prev_q    <= MID;
         lfsr_en_q <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         gap_q     <= '0;
         count_q   <= '0;
      end else if (!game_run_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         retry_q   <= '0;
         lfsr_en_q <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         lfsr_en_q <= 1'b0;
         case (state_q)
            IDLE: begin
               state_q <= WAIT;
               cnt_q   <= '0;
               count_q <= '0;
            end
            WAIT: if (frame_tick_i) begin
               if (cnt_q == LAST) begin
                  cnt_q     <= '0;
                  state_q   <= DRAW;
                  lfsr_en_q <= 1'b1;
                  busy_q    <= 1'b1;
               end else cnt_q <= cnt_q + CW'(1);
            end
            DRAW: state_q <= CHECK;
            CHECK: if (!accept_d && retry_q < RMAX) begin
               retry_q   <= retry_q + RW'(1);
               state_q   <= DRAW;
               lfsr_en_q <= 1'b1;
            end else begin
               gap_q   <= gap_d;
               prev_q  <= idx_d;
               retry_q <= '0;
               valid_q <= 1'b1;
               state_q <= OFFER;
            end
            OFFER: if (spawn_if.spawn_ready) begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               count_q <= count_q + 8'd1;
               state_q <= WAIT;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign lfsr_en_o            = lfsr_en_q;
   assign spawn_if.spawn_valid = valid_q;
   assign spawn_if.gap_y       = gap_q;
   assign spawn_count_o        = count_q;
   assign busy_o               = busy_q;
endmodule

// File: tb/tb_pipe_gap_scheduler.sv
// tb_pipe_gap_scheduler: randomized spawns scored against a rule-level gap model.
module tb_pipe_gap_scheduler;
   localparam int SF = 4, IMAX = 23, STEP = 6, MR = 3, BASE = 80, GS = 12, YW = 10;

   logic       clk = 0, rst_n = 0, game_run = 0, frame_tick = 0;
   logic [4:0] lfsr_data = 0;
   logic       lfsr_en, busy;
   logic [7:0] spawn_count;

   pipe_gap_if #(.Y_W(YW)) sif();

   pipe_gap_scheduler #(.SPAWN_FRAMES(SF), .IDX_MAX(IMAX), .MAX_STEP(STEP), .MAX_RETRY(MR),
      .GAP_BASE(BASE), .GAP_STEP(GS), .Y_W(YW)) dut (
      .clk(clk), .rst_n(rst_n), .game_run_i(game_run), .frame_tick_i(frame_tick),
      .lfsr_data_i(lfsr_data), .lfsr_en_o(lfsr_en), .spawn_if(sif),
      .spawn_count_o(spawn_count), .busy_o(busy));

   always #5 clk = ~clk;

   typedef struct {int gap; int pulses; int cnt;} exp_t;
   exp_t sb[$];
   exp_t me;
   int   draws[$];
   int   en_cnt = 0, en_mark = 0, errors = 0, checks = 0, prev = IMAX / 2, exp_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // LFSR stand-in: advances to the next queued draw on each enable pulse
   always @(posedge clk)
      if (rst_n && lfsr_en) begin
         en_cnt <= en_cnt + 1;
         if (draws.size() > 0) lfsr_data <= 5'(draws.pop_front());
         else lfsr_data <= 5'($urandom);
      end

   always @(negedge clk) begin
      if (rst_n && lfsr_en) chk("en_only_when_busy", busy, 1);
      if (rst_n && sif.spawn_valid && sif.spawn_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_spawn: gap_y %0d with empty scoreboard", sif.gap_y);
         end else begin
            me = sb.pop_front();
            chk("gap_y", int'(sif.gap_y), me.gap);
            chk("lfsr_pulses", en_cnt - en_mark, me.pulses);
            chk("spawn_count_pre", int'(spawn_count), me.cnt);
         end
      end
   end

   task automatic send_ticks();
      for (int i = 0; i < SF; i++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         frame_tick = 1;
         @(posedge clk); #1;
         frame_tick = 0;
      end
   endtask

   // returns the cycle (relative to the expiring tick) in which spawn_valid is first seen
   task automatic wait_valid(output int lat);
      lat = 1;
      while (lat < 50) begin
         @(negedge clk);
         if (sif.spawn_valid) break;
         lat++;
         @(posedge clk); #1;
      end
   endtask

   task automatic do_spawn(input int d0, d1, d2, d3, input int n, input int hold, input bit abort);
      int d[4];
      int k, idx, lat, g;
      exp_t e;
      d = '{d0, d1, d2, d3};
      for (int i = n; i < 4; i++) d[i] = $urandom_range(0, 31);
      draws.delete();
      for (int i = 0; i < 4; i++) draws.push_back(d[i]);
      en_mark = en_cnt;
      idx = -1;
      k = 0;
      while (k <= MR && idx < 0) begin
         if (d[k] <= IMAX) idx = d[k];
         k++;
      end
      if (idx < 0) idx = prev;
      if (idx > prev + STEP) idx = prev + STEP;
      if (idx < prev - STEP) idx = prev - STEP;
      if (idx < 0) idx = 0;
      if (idx > IMAX) idx = IMAX;
      prev = idx;
      e.gap = BASE + idx * GS;
      e.pulses = k;
      e.cnt = exp_cnt;
      sb.push_back(e);
      sif.spawn_ready = (hold == 0 && !abort);
      send_ticks();
      wait_valid(lat);
      chk("latency", lat, 3 + 2 * (k - 1));
      chk("busy_offer", busy, 1);
      @(posedge clk); #1;
      if (abort) begin
         game_run = 0;
         @(posedge clk); #1;
         chk("abort_valid", sif.spawn_valid, 0);
         chk("abort_busy", busy, 0);
         chk("abort_count", int'(spawn_count), exp_cnt);
         void'(sb.pop_back());
         game_run = 1;
         @(posedge clk); #1;
         exp_cnt = 0;
         chk("rerun_count", int'(spawn_count), 0);
         return;
      end
      if (hold > 0) begin
         g = int'(sif.gap_y);
         frame_tick = 1;
         repeat (hold) begin @(posedge clk); #1; end
         frame_tick = 0;
         chk("hold_valid", sif.spawn_valid, 1);
         chk("hold_gap_stable", int'(sif.gap_y), g);
         sif.spawn_ready = 1;
      end
      lat = 0;
      while (sif.spawn_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      chk("valid_drop", sif.spawn_valid, 0);
      exp_cnt = (exp_cnt + 1) & 255;
      chk("spawn_count", int'(spawn_count), exp_cnt);
   endtask

   initial begin
      int lat;
      sif.spawn_ready = 0;
      repeat (2) begin @(posedge clk); #1; end
      chk("rst_en", lfsr_en, 0);
      chk("rst_valid", sif.spawn_valid, 0);
      chk("rst_gap", int'(sif.gap_y), 0);
      chk("rst_count", int'(spawn_count), 0);
      chk("rst_busy", busy, 0);
      rst_n = 1;
      game_run = 1;
      @(posedge clk); #1;
      // draw 0 would move prev to 5; the reset must restore 11
      draws.delete();
      draws.push_back(0);
      send_ticks();
      wait_valid(lat);
      chk("pre_reset_valid", sif.spawn_valid, 1);
      #2 rst_n = 0;
      #1;
      chk("async_valid", sif.spawn_valid, 0);
      chk("async_gap", int'(sif.gap_y), 0);
      chk("async_busy", busy, 0);
      chk("async_en", lfsr_en, 0);
      chk("async_count", int'(spawn_count), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk); #1;
      do_spawn(13, 0, 0, 0, 1, 0, 0);
      do_spawn(2, 0, 0, 0, 1, 0, 0);
      do_spawn(23, 0, 0, 0, 1, 0, 0);
      do_spawn(30, 29, 7, 0, 3, 0, 0);
      do_spawn(31, 31, 31, 31, 4, 0, 0);
      do_spawn(10, 0, 0, 0, 1, 20, 0);
      do_spawn(20, 0, 0, 0, 1, 0, 1);
      do_spawn(5, 0, 0, 0, 1, 0, 0);
      repeat (260)
         do_spawn($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), 4, $urandom_range(0, 2), 0);
      repeat (2) @(posedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pipe_gap_scheduler.md
Name: pipe_gap_scheduler

Overview:
- Sequences the 5-bit Fibonacci LFSR (clk, rst_n, data[4:0]) to pick the vertical gap position of each new pipe pair in the Flappy Bird game.
- Counts frame ticks to time spawns and pulses the LFSR enable to draw a value.
- Rejects out-of-range draws and limits the step from the previous gap.
- Hands the resulting gap Y to the pipe renderer over a valid/ready handshake.

Parameters:
- SPAWN_FRAMES, 90: frame_tick count between spawns (>=1).
- IDX_MAX, 23: largest accepted gap index (0..31).
- MAX_STEP, 6: largest |new_idx - prev_idx| allowed.
- MAX_RETRY, 3: rejected draws tolerated before fallback (>=1).
- GAP_BASE, 80: gap Y in pixels for index 0.
- GAP_STEP, 12: pixels per index.
- Y_W, 10: width of gap_y.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- game_run  in  1  level; high while game is playing
- frame_tick  in  1  one-cycle pulse per video frame
- lfsr_data  in  5  current LFSR output
- lfsr_en  out  1  one-cycle advance request to LFSR
- spawn_valid  out  1  gap_y valid, held until accepted
- spawn_ready  in  1  renderer accepts spawn
- gap_y  out  Y_W  gap centre Y = GAP_BASE + idx*GAP_STEP
- spawn_count  out  8  accepted spawns, wraps 255->0
- busy  out  1  high in any state except IDLE/WAIT

Behaviour:
- Reset (async, rst_n low): state=IDLE; lfsr_en=0, spawn_valid=0, gap_y=0, spawn_count=0, busy=0; frame counter=0, retry=0, prev_idx=IDX_MAX/2 (11).
- IDLE: when game_run=1, go to WAIT with counter=0. spawn_count is cleared on each IDLE->WAIT transition.
- WAIT: each frame_tick increments counter. On the tick that makes counter==SPAWN_FRAMES, clear counter and go to DRAW.
- DRAW (1 cycle): lfsr_en=1; go to CHECK. The LFSR updates on the same edge, so CHECK sees the new value.
- CHECK (1 cycle):
  - If lfsr_data<=IDX_MAX: cand=lfsr_data.
  - Else if retry<MAX_RETRY: retry++, go back to DRAW.
  - Else: cand=prev_idx (fallback).
  - Once cand is set: clamp to prev_idx+MAX_STEP if above, or prev_idx-MAX_STEP if below; never go below 0 or above IDX_MAX.
  - gap_y <= GAP_BASE + clamped*GAP_STEP; prev_idx <= clamped; retry <= 0; go to OFFER.
- OFFER: spawn_valid=1 and gap_y stable until a cycle with spawn_ready=1. In that cycle: spawn_count++, and spawn_valid drops on the next edge; return to WAIT.
  - spawn_ready while not valid is ignored.
- Latency: the frame_tick that expires the counter is at cycle T. DRAW is at T+1, CHECK at T+2, and spawn_valid is first high at T+3 with no rejects. Each reject adds 2 cycles.
- frame_tick is ignored outside WAIT. Ticks are not accumulated during DRAW/CHECK/OFFER.
- game_run low in any state: on the next edge go to IDLE; spawn_valid, lfsr_en and counter are cleared. An in-flight spawn is dropped uncounted. prev_idx is retained.
- Arithmetic: unsigned. The clamp compare uses 6-bit signed difference. The gap_y product is computed at Y_W bits; parameters must keep GAP_BASE+IDX_MAX*GAP_STEP < 2^Y_W.
- Exactly one lfsr_en pulse per DRAW visit. lfsr_en is never asserted in any other state.

Test Plan:
- Reset mid-OFFER (SPAWN_FRAMES=4, game_run=1, 4 ticks, rst_n low for 3 cycles while spawn_valid=1) -> all outputs 0 immediately (async), state IDLE, prev_idx=11.
- SPAWN_FRAMES=4, lfsr_data=13 after the DRAW pulse, spawn_ready tied 1 -> exactly one lfsr_en pulse one cycle after the 4th tick. spawn_valid at T+3 with gap_y=80+13*12=236. spawn_count=1.
- Clamp: prev_idx=11, draw 2 -> idx 5, gap_y=140. Next spawn draws 23 -> idx 11, gap_y=212.
- Rejection: draws 30,29 then 7 with prev=11 -> three lfsr_en pulses, gap_y=80+7*12=164, spawn_valid 4 cycles later than the no-reject case.
- Fallback: draws 31,31,31,31 (MAX_RETRY=3) -> four lfsr_en pulses, then gap_y=212 (prev_idx 11).
- Backpressure/abort: spawn_ready=0 for 20 cycles -> gap_y stable and ticks ignored. Drop game_run -> spawn_valid low next edge, spawn_count unchanged. Re-raise game_run -> spawn_count=0, next spawn after 4 more ticks.
